// File: rtl/register_pipe.sv
// Retiming pipe of DEPTH registers with per-stage valids and a valid/ready handshake.
// Supports bubble-collapsing or global-stall advance, plus flush and occupancy reporting.
module register_pipe #(
  parameter int                 SZ_DATA         = 8,
  parameter int                 DEPTH           = 3,
  parameter logic [SZ_DATA-1:0] RST_STATE       = '0,
  parameter bit                 BUBBLE_COLLAPSE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SZ_DATA-1:0]           in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SZ_DATA-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int SZ_OCC = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]   r_valid;
  logic [SZ_DATA-1:0] r_data [DEPTH];
  logic [SZ_OCC-1:0]  r_occ;

  logic [DEPTH-1:0]   w_adv;
  logic [DEPTH-1:0]   w_src_valid;
  logic [SZ_DATA-1:0] w_src_data [DEPTH];
  logic [DEPTH-1:0]   w_valid_next;
  logic [DEPTH-1:0]   w_load;
  logic [SZ_OCC-1:0]  w_occ_next;
  logic               w_in_ready;

  generate
    if (BUBBLE_COLLAPSE) begin : g_collapse
      // Walk from the output back so a stage may advance whenever any hole lies ahead of it.
      always_comb begin
        logic w_chain;
        w_adv   = '0;
        w_chain = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
          w_chain  = !r_valid[i] | w_chain;
          w_adv[i] = w_chain;
        end
      end
    end else begin : g_global
      logic w_stall;
      assign w_stall = r_valid[DEPTH-1] & !out_ready;
      assign w_adv   = {DEPTH{!w_stall}};
    end
  endgenerate

  assign w_in_ready = w_adv[0] & !flush & !rst;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_src_valid[gi] = in_valid & w_in_ready;
        assign w_src_data[gi]  = in_data;
      end else begin : g_body
        assign w_src_valid[gi] = r_valid[gi-1];
        assign w_src_data[gi]  = r_data[gi-1];
      end
      // Data only moves under a valid word; flush clears valids but leaves data in place.
      assign w_load[gi]       = w_adv[gi] & w_src_valid[gi] & !flush;
      assign w_valid_next[gi] = !flush & (w_adv[gi] ? w_src_valid[gi] : r_valid[gi]);
    end
  endgenerate

  always_comb begin
    w_occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_next = w_occ_next + SZ_OCC'(w_valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RST_STATE;
      end
    end else begin
      r_valid <= w_valid_next;
      r_occ   <= w_occ_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_data[i] <= w_src_data[i];
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_register_pipe.sv
// Directed bench for register_pipe: collapse mode (a), global-stall mode (b), DEPTH=1 (c).
module tb_register_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0] in_data_a, out_data_a;
  logic [1:0] occ_a;

  logic       flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [7:0] in_data_b, out_data_b;
  logic [1:0] occ_b;

  logic       flush_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [7:0] in_data_c, out_data_c;
  logic [0:0] occ_c;

  int n_vec = 0;
  int n_err = 0;

  // Row of a directed backpressure table: drive v/d/r, expect ir before the edge, ov/od/occ after it.
  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [1:0] occ;
  } row_t;

  register_pipe #(.SZ_DATA(8), .DEPTH(3), .RST_STATE(8'hA5), .BUBBLE_COLLAPSE(1'b1)) u_pipe_a (
    .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .occupancy(occ_a)
  );

  register_pipe #(.SZ_DATA(8), .DEPTH(3), .RST_STATE(8'hA5), .BUBBLE_COLLAPSE(1'b0)) u_pipe_b (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .occupancy(occ_b)
  );

  register_pipe #(.SZ_DATA(8), .DEPTH(1), .RST_STATE(8'hA5), .BUBBLE_COLLAPSE(1'b1)) u_pipe_c (
    .clk(clk), .rst(rst), .flush(flush_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_data(out_data_c), .occupancy(occ_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid_a = 1'b1; in_data_a = 8'h77; out_ready_a = 1'b1;
    in_valid_b = 1'b1; in_data_b = 8'h77; out_ready_b = 1'b1;
    in_valid_c = 1'b1; in_data_c = 8'h77; out_ready_c = 1'b1;
    tick();
    n_vec++;
    if ({in_ready_a, in_ready_b, in_ready_c} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b expected 000", {in_ready_a, in_ready_b, in_ready_c});
    end
    tick();
    rst = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
    #1;
    n_vec++;
    if ({out_valid_a, out_valid_b, out_valid_c} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b expected 000", {out_valid_a, out_valid_b, out_valid_c});
    end
    n_vec++;
    if ({out_data_a, out_data_b, out_data_c} !== {8'hA5, 8'hA5, 8'hA5}) begin
      n_err++;
      $display("FAIL reset_out_data: got %h %h %h expected a5 a5 a5", out_data_a, out_data_b, out_data_c);
    end
    n_vec++;
    if (occ_a !== 2'd0 || occ_b !== 2'd0 || occ_c !== 1'd0) begin
      n_err++;
      $display("FAIL reset_occupancy: got %0d %0d %0d expected 0 0 0", occ_a, occ_b, occ_c);
    end
    // Nothing presented during reset may surface afterwards.
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if ({out_valid_a, out_valid_b, out_valid_c} !== 3'b000 || out_data_a !== 8'hA5) begin
        n_err++;
        $display("FAIL reset_no_accept: cycle %0d got valid %b data %h expected valid 000 data a5",
                 k, {out_valid_a, out_valid_b, out_valid_c}, out_data_a);
      end
    end
    $display("reset: done");
  endtask

  task automatic test_streaming;
    logic [7:0] exp_d [7] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    logic       exp_v [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] exp_o [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int c = 0; c < 7; c++) begin
      in_valid_a = (c < 4); in_data_a = 8'(c + 1); out_ready_a = 1'b1;
      in_valid_b = (c < 4); in_data_b = 8'(c + 1); out_ready_b = 1'b1;
      #1;
      n_vec++;
      if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
        n_err++;
        $display("FAIL stream_in_ready: cycle %0d got %b %b expected 1 1", c, in_ready_a, in_ready_b);
      end
      tick();
      n_vec++;
      if (out_valid_a !== exp_v[c] || out_valid_b !== exp_v[c]) begin
        n_err++;
        $display("FAIL stream_out_valid: cycle %0d got %b %b expected %b", c, out_valid_a, out_valid_b, exp_v[c]);
      end
      if (exp_v[c]) begin
        n_vec++;
        if (out_data_a !== exp_d[c] || out_data_b !== exp_d[c]) begin
          n_err++;
          $display("FAIL stream_out_data: cycle %0d got %h %h expected %h", c, out_data_a, out_data_b, exp_d[c]);
        end
      end
      n_vec++;
      if (occ_a !== exp_o[c] || occ_b !== exp_o[c]) begin
        n_err++;
        $display("FAIL stream_occupancy: cycle %0d got %0d %0d expected %0d", c, occ_a, occ_b, exp_o[c]);
      end
      $display("stream: cycle %0d out_valid %b out_data %h occupancy %0d", c, out_valid_a, out_data_a, occ_a);
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
  endtask

  task automatic test_backpressure_collapse;
    row_t rows [9] = '{
      {1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1},
      {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1},
      {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h10, 2'd1},
      {1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h10, 2'd2},
      {1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h10, 2'd3},
      {1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h10, 2'd3},
      {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2'd2},
      {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 2'd1},
      {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0}
    };
    for (int k = 0; k < 9; k++) begin
      in_valid_a = rows[k].v; in_data_a = rows[k].d; out_ready_a = rows[k].r;
      #1;
      n_vec++;
      if (in_ready_a !== rows[k].ir) begin
        n_err++;
        $display("FAIL bp_collapse_in_ready: row %0d got %b expected %b", k, in_ready_a, rows[k].ir);
      end
      tick();
      n_vec++;
      if (out_valid_a !== rows[k].ov || occ_a !== rows[k].occ) begin
        n_err++;
        $display("FAIL bp_collapse_state: row %0d got valid %b occ %0d expected valid %b occ %0d",
                 k, out_valid_a, occ_a, rows[k].ov, rows[k].occ);
      end
      if (rows[k].ov) begin
        n_vec++;
        if (out_data_a !== rows[k].od) begin
          n_err++;
          $display("FAIL bp_collapse_data: row %0d got %h expected %h", k, out_data_a, rows[k].od);
        end
      end
      $display("bp_collapse: row %0d in_ready %b out_valid %b out_data %h occupancy %0d",
               k, rows[k].ir, out_valid_a, out_data_a, occ_a);
    end
    in_valid_a = 1'b0;
  endtask

  task automatic test_backpressure_global;
    row_t rows [10] = '{
      {1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1},
      {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1},
      {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h10, 2'd1},
      {1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h10, 2'd1},
      {1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h10, 2'd1},
      {1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1},
      {1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2},
      {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2'd2},
      {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 2'd1},
      {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0}
    };
    for (int k = 0; k < 10; k++) begin
      in_valid_b = rows[k].v; in_data_b = rows[k].d; out_ready_b = rows[k].r;
      #1;
      n_vec++;
      if (in_ready_b !== rows[k].ir) begin
        n_err++;
        $display("FAIL bp_global_in_ready: row %0d got %b expected %b", k, in_ready_b, rows[k].ir);
      end
      tick();
      n_vec++;
      if (out_valid_b !== rows[k].ov || occ_b !== rows[k].occ) begin
        n_err++;
        $display("FAIL bp_global_state: row %0d got valid %b occ %0d expected valid %b occ %0d",
                 k, out_valid_b, occ_b, rows[k].ov, rows[k].occ);
      end
      if (rows[k].ov) begin
        n_vec++;
        if (out_data_b !== rows[k].od) begin
          n_err++;
          $display("FAIL bp_global_data: row %0d got %h expected %h", k, out_data_b, rows[k].od);
        end
      end
      $display("bp_global: row %0d in_ready %b out_valid %b out_data %h occupancy %0d",
               k, rows[k].ir, out_valid_b, out_data_b, occ_b);
    end
    in_valid_b = 1'b0;
  endtask

  task automatic test_flush;
    out_ready_a = 1'b1;
    in_valid_a = 1'b1; in_data_a = 8'h20;
    tick();
    in_data_a = 8'h21;
    tick();
    n_vec++;
    if (occ_a !== 2'd2) begin
      n_err++;
      $display("FAIL flush_pre_occupancy: got %0d expected 2", occ_a);
    end
    flush_a = 1'b1; in_valid_a = 1'b1; in_data_a = 8'h55;
    #1;
    n_vec++;
    if (in_ready_a !== 1'b0) begin
      n_err++;
      $display("FAIL flush_in_ready: got %b expected 0", in_ready_a);
    end
    tick();
    flush_a = 1'b0; in_valid_a = 1'b0;
    n_vec++;
    if (occ_a !== 2'd0 || out_valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL flush_cleared: got occ %0d valid %b expected occ 0 valid 0", occ_a, out_valid_a);
    end
    $display("flush: occupancy %0d out_valid %b after flush", occ_a, out_valid_a);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (out_valid_a !== 1'b0) begin
        n_err++;
        $display("FAIL flush_no_leak: cycle %0d got valid %b data %h expected valid 0", k, out_valid_a, out_data_a);
      end
    end
  endtask

  task automatic test_back_to_back;
    out_ready_c = 1'b1;
    in_valid_c = 1'b1; in_data_c = 8'h30;
    tick();
    n_vec++;
    if (out_valid_c !== 1'b1 || out_data_c !== 8'h30 || occ_c !== 1'd1) begin
      n_err++;
      $display("FAIL b2b_first: got valid %b data %h occ %0d expected valid 1 data 30 occ 1",
               out_valid_c, out_data_c, occ_c);
    end
    for (int k = 1; k <= 10; k++) begin
      in_data_c = 8'(8'h30 + k);
      #1;
      n_vec++;
      if (in_ready_c !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready: word %0d got %b expected 1", k, in_ready_c);
      end
      tick();
      n_vec++;
      if (out_valid_c !== 1'b1 || out_data_c !== 8'(8'h30 + k) || occ_c !== 1'd1) begin
        n_err++;
        $display("FAIL b2b_word: word %0d got valid %b data %h occ %0d expected valid 1 data %h occ 1",
                 k, out_valid_c, out_data_c, occ_c, 8'(8'h30 + k));
      end
      $display("b2b: word %0d out_data %h occupancy %0d", k, out_data_c, occ_c);
    end
    out_ready_c = 1'b0; in_data_c = 8'h99;
    #1;
    n_vec++;
    if (in_ready_c !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_full_stall_ready: got %b expected 0", in_ready_c);
    end
    tick();
    n_vec++;
    if (out_valid_c !== 1'b1 || out_data_c !== 8'h3A) begin
      n_err++;
      $display("FAIL b2b_full_stall_hold: got valid %b data %h expected valid 1 data 3a", out_valid_c, out_data_c);
    end
    out_ready_c = 1'b1; in_valid_c = 1'b0;
    tick();
    n_vec++;
    if (out_valid_c !== 1'b0 || occ_c !== 1'd0) begin
      n_err++;
      $display("FAIL b2b_drain: got valid %b occ %0d expected valid 0 occ 0", out_valid_c, occ_c);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    flush_c = 1'b0; in_valid_c = 1'b0; in_data_c = '0; out_ready_c = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure_collapse();
    test_backpressure_global();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
